// File: rtl/reu_xfer_seq.sv
// -----------------------------------------------------------------------------
// reu_xfer_seq
//   Transfer sequencer for the REU DMA engine. Once the command register
//   requests execution it takes the C64 bus via /DMA, waits START_DLY cycles
//   for the 6510 to finish its cycle, then steps one byte per BA-high cycle
//   between C64 memory and REU DRAM. It issues NextCA/NextREUA per byte,
//   VerifyErr on a verify mismatch and XferEnd on the last byte.
//
//   All state is updated on the falling edge of PHI2, the same edge on which
//   the register block samples the strobes produced here.
//
// Ports
//   PHI2          system clock (state advances on the falling edge)
//   Reset         synchronous reset, active high
//   ExecuteEN     command register execute bit
//   FF00DecodeEN  1 = start only on a CPU write to $FF00
//   FF00WR        one-cycle pulse, CPU write to $FF00 seen
//   XferType      00 stash, 01 fetch, 10 swap, 11 verify
//   Length1       length register == 1, current byte is the last one
//   BA            VIC bus-available; 0 = VIC owns the bus this cycle
//   CDIn/RAMDIn   C64 / DRAM read data
//   DMA           drives C64 /DMA (1 = asserted)
//   CBusOE        drive the C64 address bus
//   CWrite/CDOut  C64 write strobe and write data
//   RAMRead       DRAM read access
//   RAMWrite/RAMDOut DRAM write strobe and write data
//   NextCA/NextREUA  advance addresses / length, one pulse per byte
//   VerifyErr     verify mismatch pulse
//   XferEnd       last byte completed pulse
//   Busy          sequencer not idle
//   DbgState      current state encoding, for checkers and debug
//
// Handshake: there is no valid/ready pair here. A byte moves in exactly the
// cycle where the sequencer is in an access state and BA=1; NextCA/NextREUA
// mark that cycle and are consumed by the register block on the same edge.
// -----------------------------------------------------------------------------
module reu_xfer_seq #(
  parameter int START_DLY = 1
) (
  input  logic       PHI2,
  input  logic       Reset,
  input  logic       ExecuteEN,
  input  logic       FF00DecodeEN,
  input  logic       FF00WR,
  input  logic [1:0] XferType,
  input  logic       Length1,
  input  logic       BA,
  input  logic [7:0] CDIn,
  input  logic [7:0] RAMDIn,
  output logic       DMA,
  output logic       CBusOE,
  output logic       CWrite,
  output logic [7:0] CDOut,
  output logic       RAMRead,
  output logic       RAMWrite,
  output logic [7:0] RAMDOut,
  output logic       NextCA,
  output logic       NextREUA,
  output logic       VerifyErr,
  output logic       XferEnd,
  output logic       Busy,
  output logic [2:0] DbgState
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    XFER   = 3'd2,
    SWP_RD = 3'd3,
    SWP_WR = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [1:0] T_STASH  = 2'b00;
  localparam logic [1:0] T_FETCH  = 2'b01;
  localparam logic [1:0] T_SWAP   = 2'b10;
  localparam logic [1:0] T_VERIFY = 2'b11;

  localparam int CW = (START_DLY > 1) ? $clog2(START_DLY) : 1;

  state_t        state;
  state_t        stateNext;
  logic [CW-1:0] arbCnt;
  logic [1:0]    typeLat;
  logic [7:0]    cLat;
  logic [7:0]    rLat;
  logic          start;
  logic          lastArb;
  logic          mismatch;

  // Start condition only matters in IDLE; dropping ExecuteEN while waiting
  // for $FF00 simply keeps us idle.
  assign start    = (state == IDLE) && ExecuteEN && (!FF00DecodeEN || FF00WR);
  assign lastArb  = (arbCnt == CW'(START_DLY - 1));
  assign mismatch = (typeLat == T_VERIFY) && (CDIn != RAMDIn);
  assign DbgState = state;

  // ---------------------------------------------------------------------------
  // State register and data latches
  // ---------------------------------------------------------------------------
  always_ff @(negedge PHI2) begin
    if (Reset) begin
      state   <= IDLE;
      arbCnt  <= '0;
      typeLat <= 2'b00;
      cLat    <= 8'h00;
      rLat    <= 8'h00;
    end else begin
      state <= stateNext;
      // Transfer type is frozen at start so later register writes cannot
      // change a running transfer.
      if (start) typeLat <= XferType;
      if (state == ARB && !lastArb) arbCnt <= arbCnt + CW'(1);
      else                          arbCnt <= '0;
      if (state == SWP_RD && BA) begin
        cLat <= CDIn;
        rLat <= RAMDIn;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:   if (start) stateNext = ARB;
      ARB:    if (lastArb) stateNext = (typeLat == T_SWAP) ? SWP_RD : XFER;
      // A verify mismatch ends the transfer even before the last byte.
      XFER:   if (BA && (Length1 || mismatch)) stateNext = DONE;
      SWP_RD: if (BA) stateNext = SWP_WR;
      SWP_WR: if (BA) stateNext = Length1 ? DONE : SWP_RD;
      DONE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: registered state qualified by BA
  // ---------------------------------------------------------------------------
  logic advance;

  always_comb begin
    DMA       = (state != IDLE);
    Busy      = (state != IDLE);
    CBusOE    = 1'b0;
    CWrite    = 1'b0;
    CDOut     = 8'h00;
    RAMRead   = 1'b0;
    RAMWrite  = 1'b0;
    RAMDOut   = 8'h00;
    VerifyErr = 1'b0;
    advance   = 1'b0;

    if (BA) begin
      unique case (state)
        XFER: begin
          CBusOE  = 1'b1;
          advance = 1'b1;
          unique case (typeLat)
            T_STASH: begin
              RAMWrite = 1'b1;
              RAMDOut  = CDIn;
            end
            T_FETCH: begin
              RAMRead = 1'b1;
              CWrite  = 1'b1;
              CDOut   = RAMDIn;
            end
            // Swap never runs in XFER; treat it as a plain read cycle.
            T_SWAP: begin
              RAMRead = 1'b1;
            end
            T_VERIFY: begin
              RAMRead   = 1'b1;
              VerifyErr = mismatch;
            end
            default: ;
          endcase
        end
        SWP_RD: begin
          CBusOE  = 1'b1;
          RAMRead = 1'b1;
        end
        SWP_WR: begin
          CBusOE   = 1'b1;
          CWrite   = 1'b1;
          CDOut    = rLat;
          RAMWrite = 1'b1;
          RAMDOut  = cLat;
          advance  = 1'b1;
        end
        default: ;
      endcase
    end

    NextCA   = advance;
    NextREUA = advance;
    XferEnd  = advance && Length1;
  end

endmodule

// File: tb/tb_reu_xfer_seq.sv
// -----------------------------------------------------------------------------
// tb_reu_xfer_seq
//   Bench for reu_xfer_seq. A reference model of the transfer (phase flags and
//   cycle counters, derived from the transfer rules) predicts every output on
//   every cycle; directed scenarios additionally check hand-computed literals.
// -----------------------------------------------------------------------------
module tb_reu_xfer_seq;

  localparam int START_DLY = 1;

  logic       PHI2 = 1'b0;
  logic       Reset = 1'b1;
  logic       ExecuteEN = 1'b0;
  logic       FF00DecodeEN = 1'b0;
  logic       FF00WR = 1'b0;
  logic [1:0] XferType = 2'b00;
  logic       Length1 = 1'b0;
  logic       BA = 1'b0;
  logic [7:0] CDIn = 8'h00;
  logic [7:0] RAMDIn = 8'h00;
  logic       DMA, CBusOE, CWrite, RAMRead, RAMWrite;
  logic       NextCA, NextREUA, VerifyErr, XferEnd, Busy;
  logic [7:0] CDOut, RAMDOut;
  logic [2:0] DbgState;

  reu_xfer_seq #(.START_DLY(START_DLY)) dut (
    .PHI2(PHI2), .Reset(Reset), .ExecuteEN(ExecuteEN), .FF00DecodeEN(FF00DecodeEN),
    .FF00WR(FF00WR), .XferType(XferType), .Length1(Length1), .BA(BA),
    .CDIn(CDIn), .RAMDIn(RAMDIn), .DMA(DMA), .CBusOE(CBusOE), .CWrite(CWrite),
    .CDOut(CDOut), .RAMRead(RAMRead), .RAMWrite(RAMWrite), .RAMDOut(RAMDOut),
    .NextCA(NextCA), .NextREUA(NextREUA), .VerifyErr(VerifyErr), .XferEnd(XferEnd),
    .Busy(Busy), .DbgState(DbgState)
  );

  // ---------------------------------------------------------------------------
  // Clock: rising edge at 5, falling (active) edge at 10, period 10
  // ---------------------------------------------------------------------------
  always #5 PHI2 = ~PHI2;

  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Environment: stand-in for the register block length counter and memories
  // ---------------------------------------------------------------------------
  int         lenCnt = 0;
  int         total  = 0;
  logic [7:0] cArr[16];
  logic [7:0] rArr[16];
  logic       lastNext = 1'b0;

  task automatic cyc(input logic ba, input logic ex, input logic wr);
    int i;
    @(posedge PHI2);
    #1;
    if (lastNext && lenCnt > 0) lenCnt--;
    i = total - lenCnt;
    if (i < 0) i = 0;
    if (i > 15) i = 15;
    ExecuteEN = ex;
    FF00WR    = wr;
    BA        = ba;
    Length1   = (lenCnt == 1);
    CDIn      = cArr[i];
    RAMDIn    = rArr[i];
  endtask

  task automatic load(input logic [1:0] typ, input int len, input logic ff);
    XferType     = typ;
    FF00DecodeEN = ff;
    lenCnt       = len;
    total        = len;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model state and per-scenario event log
  // ---------------------------------------------------------------------------
  logic       mValid = 1'b0;
  logic       mActive = 1'b0;
  logic       mTail = 1'b0;
  logic       mHalf = 1'b0;
  int         mArb = 0;
  logic [1:0] mTyp = 2'b00;
  logic [7:0] mCl = 8'h00;
  logic [7:0] mRl = 8'h00;

  int cycN, dmaCyc, accCyc, nextCnt, xendCnt, verrCnt, bothCnt, nextNoWr;
  int stallDma, stallStrobe, firstDma, firstAcc;
  logic [7:0] ramWq[$];
  logic [7:0] cdq[$];
  logic [7:0] exp_q[$];

  task automatic clearLog();
    cycN = 0; dmaCyc = 0; accCyc = 0; nextCnt = 0; xendCnt = 0; verrCnt = 0;
    bothCnt = 0; nextNoWr = 0; stallDma = 0; stallStrobe = 0;
    firstDma = -1; firstAcc = -1;
    ramWq.delete();
    cdq.delete();
  endtask

  task automatic chkQ(input string name, input logic [7:0] got[$], input logic [7:0] exp[$]);
    chk({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(name, {24'h0, got[i]}, {24'h0, exp[i]});
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: predict outputs from the model, check, then advance model
  // ---------------------------------------------------------------------------
  logic       eOe, eCw, eRr, eRw, eAdv, eErr, eEnd, acc;
  logic [7:0] eCd, eRd;

  always begin
    @(posedge PHI2);
    #3;
    eOe = 0; eCw = 0; eRr = 0; eRw = 0; eAdv = 0; eErr = 0; eCd = 0; eRd = 0;
    acc = mActive && (mArb == 0) && !mTail;
    if (acc && BA) begin
      case (mTyp)
        2'd0: begin eOe = 1; eRw = 1; eRd = CDIn; eAdv = 1; end
        2'd1: begin eOe = 1; eRr = 1; eCw = 1; eCd = RAMDIn; eAdv = 1; end
        2'd2: begin
          eOe = 1;
          if (!mHalf) eRr = 1;
          else begin eCw = 1; eCd = mRl; eRw = 1; eRd = mCl; eAdv = 1; end
        end
        default: begin eOe = 1; eRr = 1; eAdv = 1; eErr = (CDIn != RAMDIn); end
      endcase
    end
    eEnd = eAdv && Length1;

    if (mValid) begin
      // Write data only matters while its strobe is expected.
      chk("cycle_outputs",
          {6'h0, DMA, Busy, CBusOE, CWrite, RAMRead, RAMWrite, NextCA, NextREUA,
           VerifyErr, XferEnd, (eCw ? CDOut : 8'h00), (eRw ? RAMDOut : 8'h00)},
          {6'h0, mActive, mActive, eOe, eCw, eRr, eRw, eAdv, eAdv,
           eErr, eEnd, eCd, eRd});
      cycN++;
      if (DMA) begin dmaCyc++; if (firstDma < 0) firstDma = cycN; end
      if (CBusOE) begin accCyc++; if (firstAcc < 0) firstAcc = cycN; end
      if (RAMWrite) ramWq.push_back(RAMDOut);
      if (CWrite) cdq.push_back(CDOut);
      if (NextCA) nextCnt++;
      if (NextCA && !(CWrite && RAMWrite)) nextNoWr++;
      if (XferEnd) xendCnt++;
      if (VerifyErr) verrCnt++;
      if (VerifyErr && XferEnd) bothCnt++;
      if (!BA) begin
        if (DMA) stallDma++;
        if (CBusOE | CWrite | RAMRead | RAMWrite | NextCA | NextREUA | VerifyErr | XferEnd)
          stallStrobe++;
      end
    end
    lastNext = NextCA;

    if (Reset) begin
      mActive = 0; mTail = 0; mArb = 0; mHalf = 0; mCl = 0; mRl = 0; mValid = 1;
    end else if (!mActive) begin
      if (ExecuteEN && (!FF00DecodeEN || FF00WR)) begin
        mActive = 1; mArb = START_DLY; mTyp = XferType; mHalf = 0;
      end
    end else if (mTail) begin
      mActive = 0; mTail = 0;
    end else if (mArb > 0) begin
      mArb--;
    end else if (BA) begin
      if (mTyp == 2'd2) begin
        if (!mHalf) begin mCl = CDIn; mRl = RAMDIn; end
        mHalf = !mHalf;
      end
      if (eAdv && (Length1 || eErr)) mTail = 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int waited;
    for (int i = 0; i < 16; i++) begin cArr[i] = 8'h00; rArr[i] = 8'h00; end
    clearLog();
    Reset = 1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    Reset = 0;
    cyc(1, 0, 0);
    #1;
    chk("reset_outputs", {25'h0, DMA, Busy, CBusOE, RAMWrite, RAMRead, NextCA, XferEnd}, 32'h0);

    // 1: stash, length 3
    load(2'b00, 3, 0);
    cArr[0] = 8'h11; cArr[1] = 8'h22; cArr[2] = 8'h33;
    clearLog();
    cyc(1, 1, 0);
    repeat (8) cyc(1, 0, 0);
    exp_q = '{8'h11, 8'h22, 8'h33};
    chkQ("stash_ramdout", ramWq, exp_q);
    chk("stash_next", nextCnt, 3);
    chk("stash_xferend", xendCnt, 1);
    chk("stash_dma_lead", firstAcc - firstDma, 1);
    chk("stash_dma_cycles", dmaCyc, 5);

    // 2: fetch, length 2, gated by $FF00 write
    load(2'b01, 2, 1);
    rArr[0] = 8'hA5; rArr[1] = 8'h5A;
    clearLog();
    repeat (4) cyc(1, 1, 0);
    chk("ff00_wait_dma", dmaCyc, 0);
    cyc(1, 1, 1);
    repeat (8) cyc(1, 0, 0);
    exp_q = '{8'hA5, 8'h5A};
    chkQ("fetch_cdout", cdq, exp_q);
    chk("fetch_xferend", xendCnt, 1);

    // 2b: ExecuteEN dropped while waiting on $FF00 -> never starts
    load(2'b00, 1, 1);
    clearLog();
    repeat (2) cyc(1, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    repeat (3) cyc(1, 0, 0);
    chk("ff00_abort_dma", dmaCyc, 0);

    // 3: swap, length 2
    load(2'b10, 2, 0);
    cArr[0] = 8'h01; cArr[1] = 8'h02; rArr[0] = 8'hF1; rArr[1] = 8'hF2;
    clearLog();
    cyc(1, 1, 0);
    repeat (10) cyc(1, 0, 0);
    chk("swap_access", accCyc, 4);
    exp_q = '{8'hF1, 8'hF2};
    chkQ("swap_cdout", cdq, exp_q);
    exp_q = '{8'h01, 8'h02};
    chkQ("swap_ramdout", ramWq, exp_q);
    chk("swap_next_only_wr", nextNoWr, 0);
    chk("swap_next", nextCnt, 2);

    // 4: verify, length 4, mismatch on byte 2 then on byte 4
    load(2'b11, 4, 0);
    cArr[0] = 8'h10; cArr[1] = 8'h20; cArr[2] = 8'h30; cArr[3] = 8'h40;
    rArr[0] = 8'h10; rArr[1] = 8'h21; rArr[2] = 8'h30; rArr[3] = 8'h40;
    clearLog();
    cyc(1, 1, 0);
    repeat (8) cyc(1, 0, 0);
    chk("verify_mid_err", verrCnt, 1);
    chk("verify_mid_next", nextCnt, 2);
    chk("verify_mid_xferend", xendCnt, 0);
    load(2'b11, 4, 0);
    rArr[1] = 8'h20; rArr[3] = 8'h41;
    clearLog();
    cyc(1, 1, 0);
    repeat (8) cyc(1, 0, 0);
    chk("verify_last_both", bothCnt, 1);
    chk("verify_last_next", nextCnt, 4);

    // 5: stash, length 3, BA low for 3 cycles after byte 1
    load(2'b00, 3, 0);
    cArr[0] = 8'h44; cArr[1] = 8'h55; cArr[2] = 8'h66;
    clearLog();
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    repeat (8) cyc(1, 0, 0);
    chk("stall_strobes", stallStrobe, 0);
    chk("stall_dma", stallDma, 3);
    chk("stall_next", nextCnt, 3);
    exp_q = '{8'h44, 8'h55, 8'h66};
    chkQ("stall_ramdout", ramWq, exp_q);

    // 6: reset mid-fetch after byte 1 of 5, then a clean restart
    load(2'b01, 5, 0);
    rArr[0] = 8'hC1; rArr[1] = 8'hC2;
    clearLog();
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    Reset = 1;
    cyc(1, 0, 0);
    Reset = 0;
    #1;
    chk("reset_mid_dma_busy", {30'h0, DMA, Busy}, 32'h0);
    repeat (3) cyc(1, 0, 0);
    chk("reset_mid_xferend", xendCnt, 0);
    load(2'b01, 2, 0);
    rArr[0] = 8'h3C; rArr[1] = 8'hC3;
    clearLog();
    cyc(1, 1, 0);
    repeat (8) cyc(1, 0, 0);
    exp_q = '{8'h3C, 8'hC3};
    chkQ("restart_cdout", cdq, exp_q);

    // Randomized transfers; the compare process checks every cycle
    for (int t = 0; t < 40; t++) begin
      logic ff;
      int   len;
      ff  = ($urandom_range(0, 3) == 0);
      len = $urandom_range(1, 6);
      for (int i = 0; i < 16; i++) begin
        cArr[i] = 8'($urandom_range(0, 255));
        rArr[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : cArr[i];
      end
      load(2'($urandom_range(0, 3)), len, ff);
      if (ff) begin
        repeat ($urandom_range(0, 3)) cyc(1, 1, 0);
        cyc(1, 1, 1);
      end else begin
        cyc(1, 1, 0);
      end
      waited = 0;
      while (waited < 3 || mActive) begin
        if (waited > 200) begin
          chk("random_timeout", 32'd1, 32'd0);
          break;
        end
        cyc(($urandom_range(0, 3) != 0), 0, 0);
        Reset = ($urandom_range(0, 60) == 0);
        waited++;
      end
      Reset = 0;
      cyc(1, 0, 0);
      cyc(1, 0, 0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/reu_xfer_seq.md
Name: reu_xfer_seq

Overview:
Transfer sequencer for the REU DMA engine. It watches the command register outputs (ExecuteEN, FF00DecodeEN, XferType) and the length-terminal flag. It takes the C64 bus via /DMA and steps one byte per bus cycle between C64 memory and REU DRAM. It issues the NextCA, NextREUA, VerifyErr and XferEnd strobes that the register block consumes, so it sits between the register file, the C64 expansion-port bus and the DRAM interface.

Parameters:
START_DLY, 1, PHI2 cycles between /DMA assertion and the first bus access (lets the 6510 finish its write cycle).

Ports:
PHI2  in  1  system clock; all state updates on falling edge (same edge as register block)
Reset  in  1  synchronous reset, active-high
ExecuteEN  in  1  command register execute bit
FF00DecodeEN  in  1  1 = wait for write to $FF00 before starting
FF00WR  in  1  one-cycle pulse: CPU write to $FF00 detected
XferType  in  2  00 stash C64->REU, 01 fetch REU->C64, 10 swap, 11 verify
Length1  in  1  transfer length register == 1 (current byte is last)
BA  in  1  VIC bus-available; 0 = VIC owns bus this cycle
CDIn  in  8  C64 data bus, sampled at falling edge
RAMDIn  in  8  REU DRAM read data, sampled at falling edge
DMA  out  1  drives C64 /DMA (1 = asserted, board inverts)
CBusOE  out  1  drive C64 address bus with CAOut
CWrite  out  1  C64 R/W low this cycle (write); valid only with CBusOE
CDOut  out  8  data driven to C64 when CWrite
RAMRead  out  1  DRAM read access this cycle
RAMWrite  out  1  DRAM write access this cycle
RAMDOut  out  8  DRAM write data
NextCA  out  1  advance CA / decrement length (one per byte)
NextREUA  out  1  advance REU address (one per byte)
VerifyErr  out  1  verify mismatch pulse
XferEnd  out  1  last byte completed pulse
Busy  out  1  state != IDLE

Behaviour:
- State register and data latches are registered on the falling edge of PHI2.
- Strobe outputs (CBusOE, CWrite, RAM*, Next*, VerifyErr, XferEnd) are combinational decodes of registered state AND BA. The register block samples them on the same falling edge that advances this block.
- Reset: state IDLE, latches 0x00. All outputs 0, including DMA and Busy. Reset mid-transfer returns to IDLE at that edge, so DMA drops in the next cycle. No XferEnd or VerifyErr is issued.
- Trigger: in IDLE, start when ExecuteEN && (!FF00DecodeEN || FF00WR).
  - Start captures XferType into an internal copy; later register writes do not affect the running transfer.
  - If ExecuteEN falls while waiting on FF00, stay IDLE.
- States:
  - IDLE -> ARB. ARB asserts DMA and waits START_DLY cycles.
  - ARB -> XFER, or SWP_RD for swap.
  - XFER (stash/fetch/verify): one byte per cycle in which BA=1.
  - SWP_RD -> SWP_WR -> SWP_RD...
  - DONE: one cycle, DMA still 1, then IDLE.
- BA=0 in any access state: hold state and latches. All access strobes and Next*/VerifyErr/XferEnd are 0. DMA stays 1.
- Stash (XFER, BA=1): CBusOE=1, CWrite=0, RAMWrite=1, RAMDOut=CDIn, NextCA=NextREUA=1.
- Fetch (XFER, BA=1): RAMRead=1, CBusOE=1, CWrite=1, CDOut=RAMDIn, NextCA=NextREUA=1.
- Swap:
  - SWP_RD (BA=1): C64 read and DRAM read; latch CLat<=CDIn, RLat<=RAMDIn; no Next strobes.
  - SWP_WR (BA=1): CWrite=1 with CDOut=RLat; RAMWrite=1 with RAMDOut=CLat; NextCA=NextREUA=1.
- Verify (XFER, BA=1): C64 read and DRAM read, compare CDIn vs RAMDIn.
  - Equal: NextCA=NextREUA=1.
  - Mismatch: VerifyErr=1 and NextCA=NextREUA=1 (the 1764 advances past the failing byte); next state DONE.
- Last byte: a byte-advancing cycle with Length1=1 asserts XferEnd=1 and the next state is DONE.
  - Verify mismatch on the last byte asserts VerifyErr and XferEnd together.
- Length semantics: length 0x0000 means 65536 bytes; this block only watches Length1, so no special case.
- At most one Next* pulse per byte. Swap costs 2 BA-high cycles per byte; all other types cost 1.
- DMA is 1 in ARB, XFER, SWP_*, DONE; 0 in IDLE.

Test Plan:
1. Stash, length 3, FF00DecodeEN=0, BA=1, CDIn=0x11,0x22,0x33 -> DMA high 1 cycle before access. Three RAMWrite cycles with RAMDOut 0x11/0x22/0x33, three NextCA/NextREUA pulses, XferEnd on the third, DMA low two cycles later.
2. Fetch, length 2, FF00DecodeEN=1 -> no DMA until the FF00WR pulse. Then two CWrite cycles with CDOut=RAMDIn (0xA5, 0x5A), XferEnd on the second.
3. Swap, length 2, C64 bytes 0x01,0x02, REU bytes 0xF1,0xF2 -> four access cycles. Write cycles show CDOut 0xF1/0xF2 and RAMDOut 0x01/0x02. Next* pulses only in SWP_WR.
4. Verify, length 4, mismatch on byte 2 -> VerifyErr in byte-2 cycle with two Next pulses total, no XferEnd. Repeat with mismatch on byte 4 -> VerifyErr and XferEnd together.
5. Stash, length 3, BA forced low for 3 cycles after byte 1 -> no strobes during stall, DMA held high. Bytes 2 and 3 complete after BA returns; total 3 NextCA pulses.
6. Reset asserted mid-fetch after byte 1 of 5 -> next cycle DMA=0, Busy=0, no XferEnd. A new ExecuteEN starts cleanly.
